// File: rtl/frame_feeder_pkg.sv
// +----------------------------------------------------------------------+
// | frame_feeder_pkg : shared types and constants for the frame feeder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package frame_feeder_pkg;

    localparam int DATA_W_DEFAULT = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } feeder_state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_fifo.sv
// +----------------------------------------------------------------------+
// | frame_fifo : circular word buffer with explicit occupancy count and  |
// |              the ability to flag the newest stored word as last      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       mark_last_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW-1:0]    newest_ptr;

    assign newest_ptr = wr_ptr_q - 1'b1;
    assign head_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            // Only asserted while full, so it never collides with a push.
            if (mark_last_i) begin
                mem_q[newest_ptr][WIDTH-1] <= 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_feeder.sv
// +----------------------------------------------------------------------+
// | frame_feeder : buffers upstream frames and replays each one as a     |
// |                gap-separated burst of start/data to task2            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_feeder
    import frame_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 16,
    parameter int GAP    = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         data,
    output logic                      start,
    output logic [$clog2(DEPTH):0]    frames_pending,
    output logic                      err_oversize
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              GW         = cnt_width(GAP);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [GW-1:0]   GAP_LAST   = GW'(GAP - 1);

    feeder_state_t     state_q, state_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [AW:0]       pending_q, pending_d;
    logic              err_q;

    logic [DATA_W:0]   fifo_head;
    logic [AW:0]       fifo_count;
    logic              full;
    logic              push;
    logic              pop;
    logic              oversize;
    logic              inc;
    logic              dec;

    assign full           = (fifo_count == FULL_COUNT);
    assign in_ready       = !full;
    assign push           = in_valid && !full;
    // A full buffer holding no complete frame can never drain on its own.
    assign oversize       = full && (pending_q == '0);
    assign inc            = (push && in_last) || oversize;
    assign dec            = (state_q == ST_IDLE) && (pending_q != '0);

    assign data           = data_q;
    assign start          = start_q;
    assign frames_pending = pending_q;
    assign err_oversize   = err_q;

    frame_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .push_data_i ({in_last, in_data}),
        .pop_i       (pop),
        .mark_last_i (oversize),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        data_d    = '0;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    data_d  = fifo_head[DATA_W-1:0];
                    last_d  = fifo_head[DATA_W];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // last_q tracks the word currently on the data output.
                if (last_q) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    data_d  = fifo_head[DATA_W-1:0];
                    last_d  = fifo_head[DATA_W];
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        case ({inc, dec})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            gap_cnt_q <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            data_q    <= data_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
            pending_q <= pending_d;
            err_q     <= oversize;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frame_feeder.sv
// +----------------------------------------------------------------------+
// | tb_frame_feeder : table, directed and random checks of frame_feeder  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_frame_feeder;

    localparam int DATA_W = 33;
    localparam int DEPTH  = 16;
    localparam int GAP    = 1;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] data;
    logic              start;
    logic [PW-1:0]     frames_pending;
    logic              err_oversize;

    frame_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .GAP    (GAP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .data           (data),
        .start          (start),
        .frames_pending (frames_pending),
        .err_oversize   (err_oversize)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer as a queue, frame timing as "next start allowed at edge".
    logic [DATA_W:0]   mq[$];
    int                m_pend = 0;
    bit                m_in_frame = 1'b0;
    longint            m_next_ok = 0;
    longint            m_edge = 0;
    bit                m_start = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_err = 1'b0;
    bit                m_acc = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit full;
        bit over;
        bit started;
        logic [DATA_W:0] w;
        if (reset) begin
            mq.delete();
            m_pend = 0; m_in_frame = 0; m_next_ok = 0;
            m_start = 0; m_data = '0; m_err = 0; m_acc = 0;
        end else begin
            full    = (mq.size() == DEPTH);
            m_acc   = in_valid && !full;
            over    = full && (m_pend == 0);
            started = 1'b0;
            if (over) begin
                w = mq[mq.size()-1];
                w[DATA_W] = 1'b1;
                mq[mq.size()-1] = w;
            end
            if (m_in_frame || (m_edge >= m_next_ok && m_pend > 0)) begin
                started = !m_in_frame;
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL model_underflow t=%0t actual=empty expected=word", $time);
                    w = '0;
                end else begin
                    w = mq.pop_front();
                end
                m_start = 1'b1;
                m_data  = w[DATA_W-1:0];
                m_in_frame = !w[DATA_W];
                if (w[DATA_W]) m_next_ok = m_edge + GAP + 2;
            end else begin
                m_start = 1'b0;
                m_data  = '0;
            end
            if (m_acc) mq.push_back({in_last, in_data});
            m_pend = m_pend + ((m_acc && in_last) || over ? 1 : 0) - (started ? 1 : 0);
            m_err  = over;
        end
        m_edge++;
    endtask

    task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit r);
        in_valid = v; in_data = d; in_last = l; reset = r;
        @(posedge clock);
        model_step();
        #1;
        chk("start", 64'(start), 64'(m_start));
        chk("data", 64'(data), 64'(m_data));
        chk("frames_pending", 64'(frames_pending), 64'(m_pend));
        chk("err_oversize", 64'(err_oversize), 64'(m_err));
        chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    endtask

    typedef struct {
        bit                v;
        logic [DATA_W-1:0] d;
        bit                l;
        bit                es;
        logic [DATA_W-1:0] ed;
        int                ep;
    } vec_t;

    vec_t tbl[32];

    task automatic row(input int i, input bit v, input int d, input bit l,
                       input bit s, input int ed, input int p);
        tbl[i].v = v; tbl[i].d = DATA_W'(d); tbl[i].l = l;
        tbl[i].es = s; tbl[i].ed = DATA_W'(ed); tbl[i].ep = p;
    endtask

    task automatic do_reset();
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int highs;
        int pulses;
        int run;
        int sent;
        bit saw_full;
        int runs[$];
        logic [DATA_W-1:0] got[$];

        // Single 6-word frame, then two frames queued behind a busy emitter.
        row(0, 1, 3, 0, 0, 0, 0);   row(1, 1, 4, 0, 0, 0, 0);
        row(2, 1, 5, 0, 0, 0, 0);   row(3, 1, 9, 0, 0, 0, 0);
        row(4, 1, 5, 0, 0, 0, 0);   row(5, 1, 4, 1, 0, 0, 1);
        row(6, 0, 0, 0, 1, 3, 0);   row(7, 0, 0, 0, 1, 4, 0);
        row(8, 0, 0, 0, 1, 5, 0);   row(9, 0, 0, 0, 1, 9, 0);
        row(10, 0, 0, 0, 1, 5, 0);  row(11, 0, 0, 0, 1, 4, 0);
        row(12, 0, 0, 0, 0, 0, 0);  row(13, 0, 0, 0, 0, 0, 0);
        row(14, 0, 0, 0, 0, 0, 0);
        row(15, 1, 7, 0, 0, 0, 0);  row(16, 1, 7, 0, 0, 0, 0);
        row(17, 1, 7, 0, 0, 0, 0);  row(18, 1, 7, 1, 0, 0, 1);
        row(19, 1, 3, 0, 1, 7, 0);  row(20, 1, 32, 1, 1, 7, 1);
        row(21, 1, 0, 0, 1, 7, 1);  row(22, 1, 10, 1, 1, 7, 2);
        row(23, 0, 0, 0, 0, 0, 2);  row(24, 0, 0, 0, 0, 0, 2);
        row(25, 0, 0, 0, 1, 3, 1);  row(26, 0, 0, 0, 1, 32, 1);
        row(27, 0, 0, 0, 0, 0, 1);  row(28, 0, 0, 0, 0, 0, 1);
        row(29, 0, 0, 0, 1, 0, 0);  row(30, 0, 0, 0, 1, 10, 0);
        row(31, 0, 0, 0, 0, 0, 0);

        do_reset();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_pending", 64'(frames_pending), 64'd0);
        for (int i = 0; i < 32; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].l, 1'b0);
            chk($sformatf("tbl%0d_start", i), 64'(start), 64'(tbl[i].es));
            chk($sformatf("tbl%0d_data", i), 64'(data), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d_pend", i), 64'(frames_pending), 64'(tbl[i].ep));
        end

        // Oversize: 20 words, last only on the 20th.
        do_reset();
        sent = 0; pulses = 0; run = 0;
        for (int c = 0; c < 90; c++) begin
            if (sent < 20) begin
                cyc(1'b1, DATA_W'(100 + sent), sent == 19, 1'b0);
                if (m_acc) sent++;
            end else begin
                cyc(1'b0, '0, 1'b0, 1'b0);
            end
            if (err_oversize) pulses++;
            if (start) run++;
            else if (run != 0) begin runs.push_back(run); run = 0; end
        end
        chk("oversize_sent", 64'(sent), 64'd20);
        chk("oversize_pulses", 64'(pulses), 64'd1);
        chk("oversize_nruns", 64'(runs.size()), 64'd2);
        if (runs.size() == 2) begin
            chk("oversize_run0", 64'(runs[0]), 64'd16);
            chk("oversize_run1", 64'(runs[1]), 64'd4);
        end

        // Reset in the third start-high cycle of a 6-word frame.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, DATA_W'(20 + i), i == 5, 1'b0);
        highs = 0;
        for (int c = 0; c < 10 && highs < 3; c++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            if (start) highs++;
        end
        chk("midreset_reached", 64'(highs), 64'd3);
        cyc(1'b1, DATA_W'(55), 1'b1, 1'b1);
        chk("midreset_start", 64'(start), 64'd0);
        chk("midreset_data", 64'(data), 64'd0);
        chk("midreset_pend", 64'(frames_pending), 64'd0);
        chk("midreset_ready", 64'(in_ready), 64'd1);
        highs = 0;
        for (int c = 0; c < 15; c++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            if (start) highs++;
        end
        chk("midreset_residual", 64'(highs), 64'd0);

        // Last word accepted on the edge the emitter leaves idle.
        do_reset();
        cyc(1'b1, DATA_W'(1), 1'b0, 1'b0);
        cyc(1'b1, DATA_W'(2), 1'b1, 1'b0);
        cyc(1'b1, DATA_W'(5), 1'b1, 1'b0);
        chk("simul_pend", 64'(frames_pending), 64'd1);
        got.push_back(data);
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            if (start) got.push_back(data);
        end
        chk("simul_nwords", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("simul_w0", 64'(got[0]), 64'd1);
            chk("simul_w1", 64'(got[1]), 64'd2);
            chk("simul_w2", 64'(got[2]), 64'd5);
        end

        // Saturate with single-word frames so the buffer reaches full.
        do_reset();
        saw_full = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cyc(1'b1, DATA_W'(200 + c), 1'b1, 1'b0);
            if (!in_ready) saw_full = 1'b1;
        end
        chk("full_seen", 64'(saw_full), 64'd1);
        for (int c = 0; c < 60; c++) cyc(1'b0, '0, 1'b0, 1'b0);

        // Randomised traffic with phases of rare last to provoke splits.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int lp;
            lp = ((c / 400) % 2 == 1) ? 40 : 4;
            cyc($urandom_range(0, 9) < 7,
                DATA_W'({$urandom(), $urandom()}),
                $urandom_range(0, lp - 1) == 0,
                $urandom_range(0, 499) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
